// File: rtl/ball_motion_ctrl.sv
// Ball position/direction FSM: serve from centre, timed steps, paddle/wall bounce, edge scoring.
// Optional macro BALL_SPEEDUP_EN: each paddle hit raises speed, saturating at MAX_SPEED.
module ball_motion_ctrl #(
  parameter  int FIELD_W   = 64,
  parameter  int FIELD_H   = 48,
  parameter  int BALL_SIZE = 4,
  parameter  int TICK_DIV  = 4,
  parameter  int MAX_SPEED = 3,
  localparam int X_W       = $clog2(FIELD_W),
  localparam int Y_W       = $clog2(FIELD_H),
  localparam int S_W       = $clog2(MAX_SPEED + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           serve,
  input  logic           serve_dir,
  input  logic           paddle_collision,
  input  logic           wall_collision,
  output logic [X_W-1:0] bx,
  output logic [Y_W-1:0] by,
  output logic           bx_dir,
  output logic           by_dir,
  output logic [S_W-1:0] speed,
  output logic           moving,
  output logic           score_left,
  output logic           score_right
);
  localparam int XMAX = FIELD_W - BALL_SIZE;
  localparam int YMAX = FIELD_H - BALL_SIZE;
  localparam int XC   = XMAX / 2;
  localparam int YC   = YMAX / 2;
  localparam int T_W  = $clog2(TICK_DIV);
  localparam int TL   = TICK_DIV - 1;

  localparam logic [X_W:0]   XMAX_E    = XMAX[X_W:0];
  localparam logic [Y_W:0]   YMAX_E    = YMAX[Y_W:0];
  localparam logic [X_W-1:0] X_CTR     = XC[X_W-1:0];
  localparam logic [Y_W-1:0] Y_CTR     = YC[Y_W-1:0];
  localparam logic [T_W-1:0] TICK_LAST = TL[T_W-1:0];

  typedef enum logic [1:0] {IDLE, MOVE, SCORED} state_t;

  state_t         state_q, state_d;
  logic [X_W-1:0] bx_d;
  logic [Y_W-1:0] by_d;
  logic           bx_dir_d, by_dir_d;
  logic [T_W-1:0] tick_q, tick_d;
  logic           pad_q, pad_d, wall_q, wall_d;
  logic           sl_d, sr_d;
  logic [S_W-1:0] speed_q;

  logic           pad_now, wall_now, xdir_n, ydir_n, tick_end;
  logic [X_W:0]   spd_x, x_sum;
  logic [Y_W:0]   spd_y, y_sum;
  logic           x_edge, y_edge;
  logic [X_W-1:0] x_clamp;
  logic [Y_W-1:0] y_clamp;

  assign spd_x    = {{(X_W + 1 - S_W){1'b0}}, speed_q};
  assign spd_y    = {{(Y_W + 1 - S_W){1'b0}}, speed_q};
  assign tick_end = (tick_q == TICK_LAST);
  assign moving   = (state_q == MOVE);
  assign speed    = speed_q;

  // Step arithmetic: flags (including this cycle's input) flip direction before the move.
  always_comb begin
    pad_now  = pad_q | paddle_collision;
    wall_now = wall_q | wall_collision;
    xdir_n   = bx_dir ^ pad_now;
    ydir_n   = by_dir ^ wall_now;
    if (xdir_n) begin
      x_sum   = {1'b0, bx} + spd_x;
      x_edge  = (x_sum >= XMAX_E);
      x_clamp = XMAX_E[X_W-1:0];
    end else begin
      x_sum   = {1'b0, bx} - spd_x;
      x_edge  = ({1'b0, bx} <= spd_x);
      x_clamp = '0;
    end
    if (ydir_n) begin
      y_sum   = {1'b0, by} + spd_y;
      y_edge  = (y_sum >= YMAX_E);
      y_clamp = YMAX_E[Y_W-1:0];
    end else begin
      y_sum   = {1'b0, by} - spd_y;
      y_edge  = ({1'b0, by} <= spd_y);
      y_clamp = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    bx_d     = bx;
    by_d     = by;
    bx_dir_d = bx_dir;
    by_dir_d = by_dir;
    tick_d   = tick_q;
    pad_d    = pad_q;
    wall_d   = wall_q;
    sl_d     = 1'b0;
    sr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        bx_d   = X_CTR;
        by_d   = Y_CTR;
        tick_d = '0;
        pad_d  = 1'b0;
        wall_d = 1'b0;
        if (serve) begin
          state_d  = MOVE;
          bx_dir_d = serve_dir;
          by_dir_d = 1'b1;
        end
      end
      MOVE: begin
        pad_d  = pad_now;
        wall_d = wall_now;
        tick_d = tick_q + 1'b1;
        if (tick_end) begin
          tick_d   = '0;
          pad_d    = 1'b0;
          wall_d   = 1'b0;
          bx_dir_d = xdir_n;
          // Reaching a y edge bounces: direction points back into the field.
          by_d     = y_edge ? y_clamp : y_sum[Y_W-1:0];
          by_dir_d = y_edge ? ~ydir_n : ydir_n;
          bx_d     = x_edge ? x_clamp : x_sum[X_W-1:0];
          if (x_edge && !pad_now) begin
            state_d = SCORED;
            sl_d    = xdir_n;
            sr_d    = ~xdir_n;
          end
        end
      end
      SCORED: begin
        tick_d = tick_q + 1'b1;
        if (tick_end) begin
          state_d = IDLE;
          tick_d  = '0;
          bx_d    = X_CTR;
          by_d    = Y_CTR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bx          <= X_CTR;
      by          <= Y_CTR;
      bx_dir      <= 1'b1;
      by_dir      <= 1'b1;
      tick_q      <= '0;
      pad_q       <= 1'b0;
      wall_q      <= 1'b0;
      score_left  <= 1'b0;
      score_right <= 1'b0;
    end else begin
      state_q     <= state_d;
      bx          <= bx_d;
      by          <= by_d;
      bx_dir      <= bx_dir_d;
      by_dir      <= by_dir_d;
      tick_q      <= tick_d;
      pad_q       <= pad_d;
      wall_q      <= wall_d;
      score_left  <= sl_d;
      score_right <= sr_d;
    end
  end

`ifdef BALL_SPEEDUP_EN
  localparam logic [S_W-1:0] SPD_MAX = MAX_SPEED[S_W-1:0];

  // Speed holds through SCORED and drops back to 1 as the ball recentres.
  always_ff @(posedge clk) begin
    if (reset) begin
      speed_q <= 1;
    end else if (state_q == IDLE || (state_q == SCORED && tick_end)) begin
      speed_q <= 1;
    end else if (state_q == MOVE && tick_end && pad_now && speed_q != SPD_MAX) begin
      speed_q <= speed_q + 1'b1;
    end
  end
`else
  assign speed_q = 1;
`endif

endmodule
